pipe_gap_feeder: RTL
====================

PIPE_GAP_FEEDER -- requirements
Module: pipe_gap_feeder

Interface
REQ-001 The block SHALL take one clock and an asynchronous active-low reset, with ports named Clk and Rst_n.
REQ-002 The block SHALL have parameter GAP_MIN, default 40, meaning the lowest pipe-gap row.
REQ-003 The block SHALL have parameter GAP_MAX, default 200, meaning the highest pipe-gap row; GAP_MAX-GAP_MIN+1 SHALL be between 128 and 256.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning gap-queue entries (power of two).
REQ-005 The block SHALL have parameter RESP_LAT, default 1, meaning cycles from the req pulse to a valid Num (1..3).
REQ-006 Port Clk, input, 1 bit: rising-edge system clock.
REQ-007 Port Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port req, output, 1 bit: single-cycle request pulse to the random-number source.
REQ-009 Port Num, input, 8 bits: random value from the source, valid RESP_LAT cycles after req.
REQ-010 Port pop, input, 1 bit: game logic consumes the head gap.
REQ-011 Port gap, output, 8 bits: head-of-queue gap row (show-ahead).
REQ-012 Port gap_valid, output, 1 bit: queue not empty.
REQ-013 Port count, output, $clog2(DEPTH)+1 bits: queue occupancy.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT and CAPTURE.
REQ-015 IDLE SHALL go to REQ when count < DEPTH; otherwise it SHALL stay in IDLE.
REQ-016 REQ SHALL drive req=1 for exactly one cycle, then go to WAIT; req SHALL be 0 in every other state.
REQ-017 WAIT SHALL count RESP_LAT-1 cycles and then go to CAPTURE; when RESP_LAT=1, WAIT SHALL last 0 cycles (REQ goes directly to CAPTURE).
REQ-018 CAPTURE SHALL sample Num, map it, push the result into the queue and return to IDLE.
REQ-019 Mapping: with R = GAP_MAX-GAP_MIN+1, off = Num when Num < R, else off = Num-R; gap value = GAP_MIN+off, computed in 9 bits and truncated to 8.
REQ-020 At most one request SHALL be outstanding; space is reserved at REQ time, so a CAPTURE push SHALL never overflow.
REQ-021 pop SHALL take effect when gap_valid=1; a pop while empty SHALL be ignored and SHALL change no state.
REQ-022 A pop and a push in the same cycle SHALL leave count unchanged; the head SHALL advance and the new entry SHALL be appended.
REQ-023 gap SHALL update in the cycle after a pop or after a push into an empty queue.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 While Rst_n=0: req=0, gap=0, gap_valid=0, count=0, FSM in IDLE, pointers 0, statistics cleared.
REQ-026 Reset asserted mid-request SHALL abandon the request, and a Num arriving after reset SHALL be ignored.
REQ-027 The first req SHALL occur in the second rising edge after Rst_n deasserts.

Configuration
REQ-028 With macro PIPE_GAP_STATS_EN defined, the block SHALL add output served (16 bits), counting accepted pops, saturating at 16'hFFFF, and cleared by reset.
REQ-029 Without PIPE_GAP_STATS_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package flappy_pkg SHALL hold the GAP_MIN/GAP_MAX defaults, the FSM state enum type and the gap-row width constant (8).
REQ-031 Queue storage SHALL be sub-module gap_fifo (show-ahead, parameter DEPTH, push/pop/count); the FSM and mapping SHALL stay in the top.

Verification
REQ-032 Reset release, source Num=8'd10, RESP_LAT=1, no pop -> four req pulses, queue fills with 50,50,50,50, count=4, req then stays 0.
REQ-033 Num=8'd160 then 8'd161 then 8'd255 -> gaps 200, 40, 134 in order.
REQ-034 Full queue, single pop -> exactly one new req within 2 cycles, count returns to 4.
REQ-035 Empty queue with pop held high -> count stays 0, no underflow, served unchanged (with PIPE_GAP_STATS_EN).
REQ-036 RESP_LAT=3, Num changes each cycle -> the captured value SHALL equal Num exactly 3 cycles after req.
REQ-037 Rst_n pulsed low during WAIT -> all outputs zero immediately; after release, refill restarts from IDLE with a fresh req.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants and FSM state type for the pipe-gap feeder.
package flappy_pkg;

    localparam int GAP_MIN_DEF = 40;
    localparam int GAP_MAX_DEF = 200;
    localparam int GAP_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/gap_fifo.sv
// Show-ahead gap queue. The head entry is presented combinationally and
// reads as zero while the queue is empty. A pop on an empty queue is ignored.
module gap_fifo
    import flappy_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [GAP_W-1:0]       data_in,
    input  logic                   pop,
    output logic [GAP_W-1:0]       data_out,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [GAP_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok   = pop && (count != '0);
    assign push_ok  = push && ((count != DEPTH_C) || pop_ok);
    assign data_out = (count != '0) ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (push_ok && !pop_ok)
                count <= count + CW'(1);
            else if (pop_ok && !push_ok)
                count <= count - CW'(1);
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/pipe_gap_feeder.sv
// Pipe-gap feeder: requests random numbers from an external source, folds
// them into the [GAP_MIN, GAP_MAX] row range and keeps a small queue of gaps.
// Optional feature macro: PIPE_GAP_STATS_EN adds the 16-bit "served" counter.
//
// state   | meaning
// IDLE    | wait for a free queue slot
// REQ     | one-cycle req pulse, slot is now reserved
// WAIT    | let the source settle for RESP_LAT-1 cycles
// CAPTURE | sample Num, map it and push it into the queue
module pipe_gap_feeder
    import flappy_pkg::*;
#(
    parameter int GAP_MIN  = GAP_MIN_DEF,
    parameter int GAP_MAX  = GAP_MAX_DEF,
    parameter int DEPTH    = 4,
    parameter int RESP_LAT = 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    output logic                   req,
    input  logic [GAP_W-1:0]       Num,
    input  logic                   pop,
    output logic [GAP_W-1:0]       gap,
    output logic                   gap_valid,
    output logic [$clog2(DEPTH):0] count
`ifdef PIPE_GAP_STATS_EN
    ,
    output logic [15:0]            served
`endif
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NW    = GAP_W + 1;
    localparam int RANGE = GAP_MAX - GAP_MIN + 1;
    localparam logic [NW-1:0]    RANGE_W   = NW'(RANGE);
    localparam logic [GAP_W-1:0] RANGE_N   = GAP_W'(RANGE);
    localparam logic [GAP_W-1:0] GAP_MIN_N = GAP_W'(GAP_MIN);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
    localparam logic [1:0]       WAIT_LOAD = 2'(RESP_LAT - 2);

    feeder_state_t    state;
    feeder_state_t    state_nxt;
    logic [1:0]       wait_cnt;
    logic             push;
    logic [GAP_W-1:0] off;
    logic [GAP_W-1:0] gap_in;

    // Range is at least 128, so one subtraction always lands inside it.
    // The 8-bit sum is the 9-bit result truncated.
    assign off       = ({1'b0, Num} < RANGE_W) ? Num : Num - RANGE_N;
    assign gap_in    = GAP_MIN_N + off;
    assign gap_valid = (count != '0);

    // State register; reset drops any request in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and Moore outputs.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (count < DEPTH_C)
                    state_nxt = REQ;
            end
            REQ: begin
                req       = 1'b1;
                state_nxt = (RESP_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 2'd0)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                push      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response-latency down-counter, loaded while the req pulse is out.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            wait_cnt <= 2'd0;
        else if (state == REQ)
            wait_cnt <= WAIT_LOAD;
        else if (state == WAIT && wait_cnt != 2'd0)
            wait_cnt <= wait_cnt - 2'd1;
    end

    gap_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .push    (push),
        .data_in (gap_in),
        .pop     (pop),
        .data_out(gap),
        .count   (count)
    );

`ifdef PIPE_GAP_STATS_EN
    // Accepted-pop counter, holds at all-ones.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            served <= 16'd0;
        else if (pop && gap_valid && served != 16'hFFFF)
            served <= served + 16'd1;
    end
`endif

endmodule
